// File: rtl/global_buffer_param.sv
`default_nettype none
// ============================================================================
// Module      : global_buffer_param (package)
// Description : Default parameter values shared by the global-buffer bank
//               logic, plus the byte-offset helper that splits a byte address
//               into word address and in-word byte offset.
// Revision    : 1.0 - initial release
// ============================================================================
package global_buffer_param;

    localparam int NUM_CH_DEF          = 2;
    localparam int BANK_ADDR_WIDTH_DEF = 17;
    localparam int BANK_DATA_WIDTH_DEF = 64;
    localparam int CFG_DATA_WIDTH_DEF  = 32;
    localparam int MEM_RD_LATENCY_DEF  = 3;

    // Number of address bits that select a byte inside one memory word.
    function automatic int bank_byte_offset(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int BANK_BYTE_OFFSET = bank_byte_offset(BANK_DATA_WIDTH_DEF);

endpackage
`default_nettype wire

// File: rtl/global_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : global_buffer_pkg (package)
// Description : Types shared by the global-buffer bank logic. The read tag
//               travels alongside each memory read so its data can be routed
//               back to the requester. Field widths are fixed so the type can
//               live in a package: supports up to 256 channels and 256 lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package global_buffer_pkg;

    localparam int BANK_TAG_CH_W   = 8;
    localparam int BANK_TAG_LANE_W = 8;

    typedef struct packed {
        logic                       valid;
        logic                       is_cfg;
        logic [BANK_TAG_CH_W-1:0]   ch_id;
        logic [BANK_TAG_LANE_W-1:0] lane;
    } bank_rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/glb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : glb_rr_arbiter
// Description : Round-robin arbiter. The first requester at or after the
//               pointer (modulo NUM_CH) receives the one-hot grant; the pointer
//               moves to winner+1 only on cycles where gnt_accept is high.
// Ports       : clk, reset (async, active-low)
//               req[NUM_CH]     - request vector
//               gnt_accept      - the grant was consumed this cycle
//               gnt[NUM_CH]     - one-hot grant (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module glb_rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              gnt_accept,
    output logic [NUM_CH-1:0] gnt
);

    localparam int c_ptr_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [c_ptr_w-1:0] r_rr;
    logic [c_ptr_w-1:0] w_rr_next;
    logic [c_ptr_w:0]   w_cand;
    logic               w_found;

    // Scan NUM_CH positions starting at the pointer; the extra top bit of
    // w_cand lets the sum overflow NUM_CH before being folded back.
    always_comb begin
        gnt       = '0;
        w_rr_next = r_rr;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = {1'b0, r_rr} + (c_ptr_w+1)'(k);
            if (w_cand >= (c_ptr_w+1)'(NUM_CH)) begin
                w_cand = w_cand - (c_ptr_w+1)'(NUM_CH);
            end
            if (!w_found && req[w_cand[c_ptr_w-1:0]]) begin
                w_found                  = 1'b1;
                gnt[w_cand[c_ptr_w-1:0]] = 1'b1;
                w_rr_next = (w_cand == (c_ptr_w+1)'(NUM_CH - 1)) ? '0
                          : w_cand[c_ptr_w-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr <= '0;
        end else if (gnt_accept) begin
            r_rr <= w_rr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/glb_bank_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : glb_bank_arb_ctrl
// Description : Bank controller for one global-buffer SRAM bank. Merges a
//               config (host) port and NUM_CH packet channels onto a
//               single-port memory, one access per cycle. Priority is
//               cfg write > cfg read > packet channels (round-robin). Read data
//               is routed back through a tag pipeline MEM_RD_LATENCY deep.
// Ports       : clk, reset (async, active-low)
//               pkt_wr_* / pkt_rd_*  - per-channel packed request buses
//               pkt_wr_gnt/pkt_rd_gnt - combinational grants
//               pkt_rd_data(_valid)  - per-channel read return
//               cfg_*                - config write / read port
//               mem_*                - single-port SRAM interface
// Options     : GLB_BANK_RD_HOLD_EN - when defined, read data outputs hold
//               their last returned value between valids; otherwise they are
//               zero whenever the matching valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
module glb_bank_arb_ctrl
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int NUM_CH          = NUM_CH_DEF,
    parameter int BANK_ADDR_WIDTH = BANK_ADDR_WIDTH_DEF,
    parameter int BANK_DATA_WIDTH = BANK_DATA_WIDTH_DEF,
    parameter int CFG_DATA_WIDTH  = CFG_DATA_WIDTH_DEF,
    parameter int MEM_RD_LATENCY  = MEM_RD_LATENCY_DEF
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic [NUM_CH-1:0]                   pkt_wr_en,
    input  logic [NUM_CH*BANK_ADDR_WIDTH-1:0]   pkt_wr_addr,
    input  logic [NUM_CH*BANK_DATA_WIDTH-1:0]   pkt_wr_data,
    input  logic [NUM_CH*BANK_DATA_WIDTH/8-1:0] pkt_wr_strb,
    input  logic [NUM_CH-1:0]                   pkt_rd_en,
    input  logic [NUM_CH*BANK_ADDR_WIDTH-1:0]   pkt_rd_addr,
    output logic [NUM_CH-1:0]                   pkt_wr_gnt,
    output logic [NUM_CH-1:0]                   pkt_rd_gnt,
    output logic [NUM_CH*BANK_DATA_WIDTH-1:0]   pkt_rd_data,
    output logic [NUM_CH-1:0]                   pkt_rd_data_valid,

    input  logic                                cfg_wr_en,
    input  logic [BANK_ADDR_WIDTH-1:0]          cfg_wr_addr,
    input  logic [CFG_DATA_WIDTH-1:0]           cfg_wr_data,
    input  logic                                cfg_rd_en,
    input  logic [BANK_ADDR_WIDTH-1:0]          cfg_rd_addr,
    output logic                                cfg_rd_gnt,
    output logic [CFG_DATA_WIDTH-1:0]           cfg_rd_data,
    output logic                                cfg_rd_data_valid,

    output logic                                mem_wr_en,
    output logic                                mem_rd_en,
    output logic [BANK_ADDR_WIDTH-1:0]          mem_addr,
    output logic [BANK_DATA_WIDTH-1:0]          mem_data_in,
    output logic [BANK_DATA_WIDTH-1:0]          mem_data_in_bit_sel,
    input  logic [BANK_DATA_WIDTH-1:0]          mem_data_out
);

    localparam int c_strb_w      = BANK_DATA_WIDTH / 8;
    localparam int c_num_lanes   = BANK_DATA_WIDTH / CFG_DATA_WIDTH;
    localparam int c_lane_w      = (c_num_lanes > 1) ? $clog2(c_num_lanes) : 1;
    localparam int c_byte_offset = bank_byte_offset(BANK_DATA_WIDTH);

    // ------------------------------------------------------------------------
    // Request qualification. Everything is gated by reset so the memory sees
    // no traffic and no grants are issued while the block is held in reset.
    // ------------------------------------------------------------------------
    logic [c_lane_w-1:0] w_wr_lane;
    logic [c_lane_w-1:0] w_rd_lane;
    logic                w_cfg_wr;
    logic                w_cfg_rd;
    logic                w_pkt_slot;
    logic                w_pkt_accept;
    logic [NUM_CH-1:0]   w_pkt_req;
    logic [NUM_CH-1:0]   w_arb_gnt;

    if (c_num_lanes > 1) begin : g_lane_multi
        assign w_wr_lane = cfg_wr_addr[c_byte_offset-1 -: c_lane_w];
        assign w_rd_lane = cfg_rd_addr[c_byte_offset-1 -: c_lane_w];
    end else begin : g_lane_single
        assign w_wr_lane = '0;
        assign w_rd_lane = '0;
    end

    assign w_pkt_req    = pkt_wr_en | pkt_rd_en;
    assign w_cfg_wr     = reset & cfg_wr_en;
    assign w_cfg_rd     = reset & cfg_rd_en & ~cfg_wr_en;
    assign w_pkt_slot   = reset & ~cfg_wr_en & ~cfg_rd_en;
    // The pointer only advances when a packet channel actually owns the slot.
    assign w_pkt_accept = w_pkt_slot & (|w_pkt_req);

    glb_rr_arbiter #(
        .NUM_CH     (NUM_CH)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .req        (w_pkt_req),
        .gnt_accept (w_pkt_accept),
        .gnt        (w_arb_gnt)
    );

    // ------------------------------------------------------------------------
    // Memory access mux and grant generation.
    // ------------------------------------------------------------------------
    bank_rd_tag_t w_tag_in;

    always_comb begin
        mem_wr_en           = 1'b0;
        mem_rd_en           = 1'b0;
        mem_addr            = '0;
        mem_data_in         = '0;
        mem_data_in_bit_sel = '0;
        cfg_rd_gnt          = 1'b0;
        pkt_wr_gnt          = '0;
        pkt_rd_gnt          = '0;
        w_tag_in            = '0;

        if (w_cfg_wr) begin
            mem_wr_en = 1'b1;
            mem_addr  = cfg_wr_addr;
            for (int l = 0; l < c_num_lanes; l++) begin
                if (w_wr_lane == c_lane_w'(l)) begin
                    mem_data_in[l*CFG_DATA_WIDTH +: CFG_DATA_WIDTH]         = cfg_wr_data;
                    mem_data_in_bit_sel[l*CFG_DATA_WIDTH +: CFG_DATA_WIDTH] = '1;
                end
            end
        end else if (w_cfg_rd) begin
            mem_rd_en       = 1'b1;
            mem_addr        = cfg_rd_addr;
            cfg_rd_gnt      = 1'b1;
            w_tag_in.valid  = 1'b1;
            w_tag_in.is_cfg = 1'b1;
            w_tag_in.lane   = BANK_TAG_LANE_W'(w_rd_lane);
        end else if (w_pkt_slot) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_arb_gnt[i]) begin
                    // A write beats a read from the same channel, so a
                    // write-then-read to one address always observes the write.
                    if (pkt_wr_en[i]) begin
                        pkt_wr_gnt[i] = 1'b1;
                        mem_wr_en     = 1'b1;
                        mem_addr      = pkt_wr_addr[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
                        mem_data_in   = pkt_wr_data[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
                        for (int b = 0; b < c_strb_w; b++) begin
                            mem_data_in_bit_sel[b*8 +: 8] = {8{pkt_wr_strb[i*c_strb_w + b]}};
                        end
                    end else begin
                        pkt_rd_gnt[i]  = 1'b1;
                        mem_rd_en      = 1'b1;
                        mem_addr       = pkt_rd_addr[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
                        w_tag_in.valid = 1'b1;
                        w_tag_in.ch_id = BANK_TAG_CH_W'(i);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response tag pipeline: the tail entry lines up with mem_data_out.
    // ------------------------------------------------------------------------
    bank_rd_tag_t r_tag [MEM_RD_LATENCY];
    bank_rd_tag_t w_tail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < MEM_RD_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int s = 1; s < MEM_RD_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tail = r_tag[MEM_RD_LATENCY-1];

    // ------------------------------------------------------------------------
    // Config read return.
    // ------------------------------------------------------------------------
    logic                      w_cfg_hit;
    logic [CFG_DATA_WIDTH-1:0] w_cfg_lane_data;

    assign w_cfg_hit = w_tail.valid & w_tail.is_cfg;

    always_comb begin
        w_cfg_lane_data = '0;
        for (int l = 0; l < c_num_lanes; l++) begin
            if (w_tail.lane == BANK_TAG_LANE_W'(l)) begin
                w_cfg_lane_data = mem_data_out[l*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
            end
        end
    end

    assign cfg_rd_data_valid = w_cfg_hit;

`ifdef GLB_BANK_RD_HOLD_EN
    logic [CFG_DATA_WIDTH-1:0] r_cfg_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_hold <= '0;
        end else if (w_cfg_hit) begin
            r_cfg_hold <= w_cfg_lane_data;
        end
    end

    assign cfg_rd_data = w_cfg_hit ? w_cfg_lane_data : r_cfg_hold;
`else
    assign cfg_rd_data = w_cfg_hit ? w_cfg_lane_data : '0;
`endif

    // ------------------------------------------------------------------------
    // Packet read return, one lane of logic per channel.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_pkt_rd_out
        logic w_hit;

        assign w_hit = w_tail.valid & ~w_tail.is_cfg
                     & (w_tail.ch_id == BANK_TAG_CH_W'(i));
        assign pkt_rd_data_valid[i] = w_hit;

`ifdef GLB_BANK_RD_HOLD_EN
        logic [BANK_DATA_WIDTH-1:0] r_hold;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_hold <= '0;
            end else if (w_hit) begin
                r_hold <= mem_data_out;
            end
        end

        assign pkt_rd_data[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH] = w_hit ? mem_data_out : r_hold;
`else
        assign pkt_rd_data[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH] = w_hit ? mem_data_out : '0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_glb_bank_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_glb_bank_arb_ctrl
// Description : Directed self-checking bench for glb_bank_arb_ctrl with the
//               default parameters (2 channels, 64-bit words, latency 3).
//               Includes a byte-maskable SRAM model with matching latency.
//               Honors GLB_BANK_RD_HOLD_EN for the between-valid data checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glb_bank_arb_ctrl;

`ifdef GLB_BANK_RD_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [1:0]    pkt_wr_en;
    logic [33:0]   pkt_wr_addr;
    logic [127:0]  pkt_wr_data;
    logic [15:0]   pkt_wr_strb;
    logic [1:0]    pkt_rd_en;
    logic [33:0]   pkt_rd_addr;
    logic [1:0]    pkt_wr_gnt;
    logic [1:0]    pkt_rd_gnt;
    logic [127:0]  pkt_rd_data;
    logic [1:0]    pkt_rd_data_valid;
    logic          cfg_wr_en;
    logic [16:0]   cfg_wr_addr;
    logic [31:0]   cfg_wr_data;
    logic          cfg_rd_en;
    logic [16:0]   cfg_rd_addr;
    logic          cfg_rd_gnt;
    logic [31:0]   cfg_rd_data;
    logic          cfg_rd_data_valid;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [16:0]   mem_addr;
    logic [63:0]   mem_data_in;
    logic [63:0]   mem_data_in_bit_sel;
    logic [63:0]   mem_data_out;

    int n_vec = 0;
    int n_err = 0;

    glb_bank_arb_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .pkt_wr_en           (pkt_wr_en),
        .pkt_wr_addr         (pkt_wr_addr),
        .pkt_wr_data         (pkt_wr_data),
        .pkt_wr_strb         (pkt_wr_strb),
        .pkt_rd_en           (pkt_rd_en),
        .pkt_rd_addr         (pkt_rd_addr),
        .pkt_wr_gnt          (pkt_wr_gnt),
        .pkt_rd_gnt          (pkt_rd_gnt),
        .pkt_rd_data         (pkt_rd_data),
        .pkt_rd_data_valid   (pkt_rd_data_valid),
        .cfg_wr_en           (cfg_wr_en),
        .cfg_wr_addr         (cfg_wr_addr),
        .cfg_wr_data         (cfg_wr_data),
        .cfg_rd_en           (cfg_rd_en),
        .cfg_rd_addr         (cfg_rd_addr),
        .cfg_rd_gnt          (cfg_rd_gnt),
        .cfg_rd_data         (cfg_rd_data),
        .cfg_rd_data_valid   (cfg_rd_data_valid),
        .mem_wr_en           (mem_wr_en),
        .mem_rd_en           (mem_rd_en),
        .mem_addr            (mem_addr),
        .mem_data_in         (mem_data_in),
        .mem_data_in_bit_sel (mem_data_in_bit_sel),
        .mem_data_out        (mem_data_out)
    );

    always #5 clk = ~clk;

    // SRAM model: word index from byte address bits [8:3], 3-cycle read
    // latency, junk on the output when no read was issued.
    logic [63:0] mem_model [0:63];
    logic [63:0] rd_pipe   [0:2];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem_model[mem_addr[8:3]] <= (mem_model[mem_addr[8:3]] & ~mem_data_in_bit_sel)
                                      | (mem_data_in & mem_data_in_bit_sel);
        end
        rd_pipe[0] <= mem_rd_en ? mem_model[mem_addr[8:3]] : 64'hA5A5_A5A5_A5A5_A5A5;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end

    assign mem_data_out = rd_pipe[2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pkt_wr_en   = '0;
        pkt_rd_en   = '0;
        pkt_wr_addr = '0;
        pkt_rd_addr = '0;
        pkt_wr_data = '0;
        pkt_wr_strb = '0;
        cfg_wr_en   = 1'b0;
        cfg_rd_en   = 1'b0;
        cfg_wr_addr = '0;
        cfg_rd_addr = '0;
        cfg_wr_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_gnt;
        logic [1:0] exp_vld;

        clk   = 1'b0;
        reset = 1'b0;
        for (int w = 0; w < 64; w++) mem_model[w] = '0;
        for (int s = 0; s < 3; s++) rd_pipe[s] = '0;

        // ---------------- reset with every request asserted ----------------
        pkt_wr_en   = 2'b11;
        pkt_rd_en   = 2'b11;
        pkt_wr_addr = {17'h40, 17'h48};
        pkt_rd_addr = {17'h50, 17'h58};
        pkt_wr_data = {128{1'b1}};
        pkt_wr_strb = '1;
        cfg_wr_en   = 1'b1;
        cfg_rd_en   = 1'b1;
        cfg_wr_addr = 17'h1C;
        cfg_rd_addr = 17'h1C;
        cfg_wr_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_bit_sel", mem_data_in_bit_sel, 0);
        chk("rst_pkt_wr_gnt", pkt_wr_gnt, 0);
        chk("rst_pkt_rd_gnt", pkt_rd_gnt, 0);
        chk("rst_cfg_rd_gnt", cfg_rd_gnt, 0);
        chk("rst_pkt_valid", pkt_rd_data_valid, 0);
        chk("rst_cfg_valid", cfg_rd_data_valid, 0);
        chk("rst_pkt_data", pkt_rd_data, 0);
        chk("rst_cfg_data", cfg_rd_data, 0);
        idle();
        reset = 1'b1;

        // ---------------- config write lane 1, then lane 0 ----------------
        tick();
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 17'h0C;
        cfg_wr_data = 32'hDEAD_BEEF;
        #1;
        chk("cfgwr1_en", mem_wr_en, 1);
        chk("cfgwr1_addr", mem_addr, 17'h0C);
        chk("cfgwr1_data", mem_data_in, 64'hDEAD_BEEF_0000_0000);
        chk("cfgwr1_bitsel", mem_data_in_bit_sel, 64'hFFFF_FFFF_0000_0000);

        tick();
        cfg_wr_addr = 17'h10;
        cfg_wr_data = 32'h1234_5678;
        #1;
        chk("cfgwr0_data", mem_data_in, 64'h0000_0000_1234_5678);
        chk("cfgwr0_bitsel", mem_data_in_bit_sel, 64'h0000_0000_FFFF_FFFF);

        // ---------------- config read back lane 1 ----------------
        tick();
        cfg_wr_en   = 1'b0;
        cfg_rd_en   = 1'b1;
        cfg_rd_addr = 17'h0C;
        #1;
        chk("cfgrd_gnt", cfg_rd_gnt, 1);
        chk("cfgrd_mem_rd_en", mem_rd_en, 1);
        chk("cfgrd_mem_addr", mem_addr, 17'h0C);
        tick();
        cfg_rd_en = 1'b0;
        #1;
        chk("cfgrd_vld_g1", cfg_rd_data_valid, 0);
        tick();
        #1;
        chk("cfgrd_vld_g2", cfg_rd_data_valid, 0);
        tick();
        #1;
        chk("cfgrd_vld_g3", cfg_rd_data_valid, 1);
        chk("cfgrd_data_g3", cfg_rd_data, 32'hDEAD_BEEF);
        tick();
        #1;
        chk("cfgrd_vld_g4", cfg_rd_data_valid, 0);
        chk("cfgrd_data_g4", cfg_rd_data, HOLD ? 32'hDEAD_BEEF : 32'h0);

        // ---------------- both channels streaming reads ----------------
        for (int k = 0; k < 7; k++) begin
            tick();
            pkt_rd_en   = (k < 4) ? 2'b11 : 2'b00;
            pkt_rd_addr = {17'h10, 17'h0C};
            #1;
            exp_gnt = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            exp_vld = (k < 3)  ? 2'b00 : (((k - 3) % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("stream_gnt_%0d", k), pkt_rd_gnt, exp_gnt);
            chk($sformatf("stream_vld_%0d", k), pkt_rd_data_valid, exp_vld);
            if (exp_vld == 2'b01) chk($sformatf("stream_d0_%0d", k), pkt_rd_data[63:0], 64'hDEAD_BEEF_0000_0000);
            if (exp_vld == 2'b10) chk($sformatf("stream_d1_%0d", k), pkt_rd_data[127:64], 64'h0000_0000_1234_5678);
        end

        // ---------------- ch0 write + read to 0x10 together ----------------
        tick();
        pkt_wr_en          = 2'b01;
        pkt_rd_en          = 2'b01;
        pkt_wr_addr[16:0]  = 17'h10;
        pkt_rd_addr[16:0]  = 17'h10;
        pkt_wr_data[63:0]  = 64'h0123_4567_89AB_CDEF;
        pkt_wr_strb[7:0]   = 8'hF0;
        #1;
        chk("wbr_wr_gnt", pkt_wr_gnt, 2'b01);
        chk("wbr_rd_gnt_c0", pkt_rd_gnt, 2'b00);
        chk("wbr_mem_wr_en", mem_wr_en, 1);
        chk("wbr_mem_rd_en", mem_rd_en, 0);
        chk("wbr_data", mem_data_in, 64'h0123_4567_89AB_CDEF);
        chk("wbr_bitsel", mem_data_in_bit_sel, 64'hFFFF_FFFF_0000_0000);
        tick();
        pkt_wr_en = 2'b00;
        #1;
        chk("wbr_rd_gnt_c1", pkt_rd_gnt, 2'b01);
        chk("wbr_rd_addr", mem_addr, 17'h10);
        tick();
        pkt_rd_en = 2'b00;
        #1;
        chk("wbr_vld_g1", pkt_rd_data_valid, 2'b00);
        chk("wbr_hold_d0", pkt_rd_data[63:0], HOLD ? 64'hDEAD_BEEF_0000_0000 : 64'h0);
        chk("wbr_hold_d1", pkt_rd_data[127:64], HOLD ? 64'h0000_0000_1234_5678 : 64'h0);
        tick();
        #1;
        chk("wbr_vld_g2", pkt_rd_data_valid, 2'b00);
        tick();
        #1;
        chk("wbr_vld_g3", pkt_rd_data_valid, 2'b01);
        chk("wbr_data_g3", pkt_rd_data[63:0], 64'h0123_4567_1234_5678);

        // ------- cfg write held 4 cycles while both channels read pend -------
        for (int k = 0; k < 4; k++) begin
            tick();
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = 17'h20;
            cfg_wr_data = 32'hCAFE_F00D;
            cfg_rd_en   = 1'b1;
            cfg_rd_addr = 17'h0C;
            pkt_rd_en   = 2'b11;
            pkt_rd_addr = {17'h10, 17'h0C};
            #1;
            chk($sformatf("cfgblk_rd_gnt_%0d", k), pkt_rd_gnt, 2'b00);
            chk($sformatf("cfgblk_wr_gnt_%0d", k), pkt_wr_gnt, 2'b00);
            chk($sformatf("cfgblk_cfg_gnt_%0d", k), cfg_rd_gnt, 0);
            chk($sformatf("cfgblk_mem_rd_%0d", k), mem_rd_en, 0);
            chk($sformatf("cfgblk_mem_wr_%0d", k), mem_wr_en, 1);
        end
        tick();
        cfg_wr_en = 1'b0;
        cfg_rd_en = 1'b0;
        #1;
        chk("cfgblk_resume_ch1", pkt_rd_gnt, 2'b10);
        tick();
        pkt_rd_en = 2'b01;
        #1;
        chk("cfgblk_next_ch0", pkt_rd_gnt, 2'b01);
        tick();
        pkt_rd_en = 2'b00;
        #1;
        chk("cfgblk_vld_g2", pkt_rd_data_valid, 2'b00);
        tick();
        #1;
        chk("cfgblk_vld_ch1", pkt_rd_data_valid, 2'b10);
        chk("cfgblk_d1", pkt_rd_data[127:64], 64'h0123_4567_1234_5678);
        tick();
        #1;
        chk("cfgblk_vld_ch0", pkt_rd_data_valid, 2'b01);
        chk("cfgblk_d0", pkt_rd_data[63:0], 64'hDEAD_BEEF_0000_0000);

        // ---------------- reset right after a read grant ----------------
        tick();
        pkt_rd_en = 2'b01;
        #1;
        chk("rstmid_gnt", pkt_rd_gnt, 2'b01);
        tick();
        pkt_rd_en = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_in_rst_vld", pkt_rd_data_valid, 2'b00);
        chk("rstmid_in_rst_data", pkt_rd_data, 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rstmid_vld_%0d", k), pkt_rd_data_valid, 2'b00);
            chk($sformatf("rstmid_data_%0d", k), pkt_rd_data, 0);
            chk($sformatf("rstmid_cfg_vld_%0d", k), cfg_rd_data_valid, 0);
            tick();
        end

        // pointer restarts at channel 0 after reset
        pkt_rd_en   = 2'b11;
        pkt_rd_addr = {17'h10, 17'h0C};
        #1;
        chk("post_rst_rr", pkt_rd_gnt, 2'b01);
        tick();
        pkt_rd_en = 2'b00;
        tick();
        tick();
        #1;
        chk("post_rst_vld", pkt_rd_data_valid, 2'b01);
        chk("post_rst_data", pkt_rd_data[63:0], 64'hDEAD_BEEF_0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
